// File: rtl/line_anim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_anim_pkg
// Description : Shared types for the line_animator sequencer. Contains the
//               FSM state encoding, the perimeter edge encoding, the
//               screen-coordinate types and an edge-ordering helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package line_anim_pkg;

    typedef enum logic [2:0] {
        CLR_ISSUE   = 3'd0,
        CLR_WAIT    = 3'd1,
        DRAW_ISSUE  = 3'd2,
        DRAW_WAIT   = 3'd3,
        IDLE        = 3'd4,
        ERASE_ISSUE = 3'd5,
        ERASE_WAIT  = 3'd6,
        STEP        = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        RIGHT  = 2'd1,
        BOTTOM = 2'd2,
        LEFT   = 2'd3
    } edge_t;

    typedef logic [9:0] xcoord_t;
    typedef logic [8:0] ycoord_t;

    // Clockwise walk around the screen: TOP > RIGHT > BOTTOM > LEFT > TOP.
    function automatic edge_t next_edge(input edge_t e);
        case (e)
            TOP:     return RIGHT;
            RIGHT:   return BOTTOM;
            BOTTOM:  return LEFT;
            default: return TOP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/perimeter_walker.sv
`default_nettype none
// ============================================================================
// Module      : perimeter_walker
// Description : Holds the current (edge, pos) point on the screen perimeter
//               and presents the matching endpoint combinationally. A pulse
//               on advance moves the point STEP pixels clockwise; when the
//               step would reach the last pixel of an edge the walk jumps to
//               pos 0 of the next edge (the corner), dropping any remainder.
// Ports       : clk      in   system clock
//               reset_n  in   asynchronous active-low reset (edge=TOP, pos=0)
//               advance  in   1-cycle request to move to the next point
//               end_x    out  endpoint x (10 bits)
//               end_y    out  endpoint y (9 bits)
// Revision    : 1.0 - initial release
// ============================================================================
module perimeter_walker
    import line_anim_pkg::*;
#(
    parameter int W    = 640,
    parameter int H    = 480,
    parameter int STEP = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       advance,
    output logic [9:0] end_x,
    output logic [8:0] end_y
);

    localparam logic [10:0] c_W_LEN = 11'(W);
    localparam logic [10:0] c_H_LEN = 11'(H);
    localparam logic [10:0] c_STEP  = 11'(STEP);
    localparam logic [10:0] c_X_MAX = 11'(W - 1);
    localparam logic [10:0] c_Y_MAX = 11'(H - 1);

    edge_t       r_edge;
    logic [10:0] r_pos;
    logic [10:0] w_len;
    logic [10:0] w_sum;

    always_comb begin
        w_len = ((r_edge == TOP) || (r_edge == BOTTOM)) ? c_W_LEN : c_H_LEN;
        w_sum = r_pos + c_STEP;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge <= TOP;
            r_pos  <= '0;
        end else if (advance) begin
            if (w_sum >= (w_len - 11'd1)) begin
                r_edge <= next_edge(r_edge);
                r_pos  <= '0;
            end else begin
                r_pos  <= w_sum;
            end
        end
    end

    // pos never exceeds the edge length, so the narrowing casts are lossless.
    always_comb begin
        end_x = '0;
        end_y = '0;
        case (r_edge)
            TOP: begin
                end_x = 10'(r_pos);
                end_y = '0;
            end
            RIGHT: begin
                end_x = 10'(c_X_MAX);
                end_y = 9'(r_pos);
            end
            BOTTOM: begin
                end_x = 10'(c_X_MAX - r_pos);
                end_y = 9'(c_Y_MAX);
            end
            default: begin
                end_x = '0;
                end_y = 9'(c_Y_MAX - r_pos);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/line_animator.sv
`default_nettype none
// ============================================================================
// Module      : line_animator
// Description : Sequencer feeding line_drawer, one line per start/done
//               handshake. After reset it clears the screen as H colour-0
//               rows, then draws a radial line from (CX,CY) to a point that
//               walks the perimeter. Every FRAMES_PER_STEP frames the old
//               line is erased and the next one drawn. A clear request is
//               latched and serviced at the next IDLE.
// Ports       : clk          in   system clock
//               reset_n      in   asynchronous active-low reset
//               frame_start  in   1-cycle pulse per video frame
//               clear_req    in   request a full-screen clear
//               pause        in   freeze frame counting in IDLE
//               drawer_done  in   1-cycle pulse, current line finished
//               drawer_start out  1-cycle pulse, endpoints/colour valid
//               x0, y0       out  line start point
//               x1, y1       out  line end point
//               pixel_color  out  0 = erase, 1 = draw
//               busy         out  high during the clear sweep
// Revision    : 1.0 - initial release
// ============================================================================
module line_animator
    import line_anim_pkg::*;
#(
    parameter int W               = 640,
    parameter int H               = 480,
    parameter int CX              = 320,
    parameter int CY              = 240,
    parameter int STEP            = 8,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       clear_req,
    input  logic       pause,
    input  logic       drawer_done,
    output logic       drawer_start,
    output logic [9:0] x0,
    output logic [9:0] x1,
    output logic [8:0] y0,
    output logic [8:0] y1,
    output logic       pixel_color,
    output logic       busy
);

    localparam logic [9:0] c_X_MAX = 10'(W - 1);
    localparam logic [8:0] c_Y_MAX = 9'(H - 1);
    localparam logic [9:0] c_CX    = 10'(CX);
    localparam logic [8:0] c_CY    = 9'(CY);
    localparam logic [7:0] c_FPS   = 8'(FRAMES_PER_STEP);

    state_t     r_state, w_state;
    logic [8:0] r_row, w_row;
    logic [7:0] r_count, w_count;
    logic       r_clear_pending, w_clear_pending;
    logic       w_start, w_color, w_busy, w_advance, w_in_clear;
    logic [9:0] w_x0, w_x1, w_end_x;
    logic [8:0] w_y0, w_y1, w_end_y;

    perimeter_walker #(
        .W    (W),
        .H    (H),
        .STEP (STEP)
    ) u_walker (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (w_advance),
        .end_x   (w_end_x),
        .end_y   (w_end_y)
    );

    always_comb begin
        w_state         = r_state;
        w_row           = r_row;
        w_count         = r_count;
        w_clear_pending = r_clear_pending;
        w_start         = 1'b0;
        w_x0            = x0;
        w_y0            = y0;
        w_x1            = x1;
        w_y1            = y1;
        w_color         = pixel_color;
        w_advance       = 1'b0;
        w_in_clear      = (r_state == CLR_ISSUE) || (r_state == CLR_WAIT);

        // A request raised in the same cycle IDLE is evaluated must already
        // count, so IDLE looks at the combined value rather than the flop.
        if (clear_req && !w_in_clear) begin
            w_clear_pending = 1'b1;
        end

        case (r_state)
            CLR_ISSUE: begin
                w_x0    = '0;
                w_y0    = r_row;
                w_x1    = c_X_MAX;
                w_y1    = r_row;
                w_color = 1'b0;
                w_start = 1'b1;
                w_state = CLR_WAIT;
            end
            CLR_WAIT: begin
                if (drawer_done) begin
                    if (r_row == c_Y_MAX) begin
                        w_row   = '0;
                        w_state = DRAW_ISSUE;
                    end else begin
                        w_row   = r_row + 9'd1;
                        w_state = CLR_ISSUE;
                    end
                end
            end
            DRAW_ISSUE: begin
                w_x0    = c_CX;
                w_y0    = c_CY;
                w_x1    = w_end_x;
                w_y1    = w_end_y;
                w_color = 1'b1;
                w_start = 1'b1;
                w_state = DRAW_WAIT;
            end
            DRAW_WAIT: begin
                if (drawer_done) begin
                    w_count = '0;
                    w_state = IDLE;
                end
            end
            IDLE: begin
                if (w_clear_pending) begin
                    w_clear_pending = 1'b0;
                    w_count         = '0;
                    w_state         = CLR_ISSUE;
                end else if (frame_start && !pause) begin
                    if ((r_count + 8'd1) >= c_FPS) begin
                        w_count = '0;
                        w_state = ERASE_ISSUE;
                    end else begin
                        w_count = r_count + 8'd1;
                    end
                end
            end
            ERASE_ISSUE: begin
                w_x0    = c_CX;
                w_y0    = c_CY;
                w_x1    = w_end_x;
                w_y1    = w_end_y;
                w_color = 1'b0;
                w_start = 1'b1;
                w_state = ERASE_WAIT;
            end
            ERASE_WAIT: begin
                if (drawer_done) begin
                    w_state = line_anim_pkg::STEP;
                end
            end
            line_anim_pkg::STEP: begin
                w_advance = 1'b1;
                w_state   = DRAW_ISSUE;
            end
            default: begin
                w_state = CLR_ISSUE;
            end
        endcase

        w_busy = (w_state == CLR_ISSUE) || (w_state == CLR_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= CLR_ISSUE;
            r_row           <= '0;
            r_count         <= '0;
            r_clear_pending <= 1'b0;
            drawer_start    <= 1'b0;
            x0              <= '0;
            y0              <= '0;
            x1              <= '0;
            y1              <= '0;
            pixel_color     <= 1'b0;
            busy            <= 1'b1;
        end else begin
            r_state         <= w_state;
            r_row           <= w_row;
            r_count         <= w_count;
            r_clear_pending <= w_clear_pending;
            drawer_start    <= w_start;
            x0              <= w_x0;
            y0              <= w_y0;
            x1              <= w_x1;
            y1              <= w_y1;
            pixel_color     <= w_color;
            busy            <= w_busy;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_animator.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_animator
// Description : Scoreboard bench for line_animator. Stimulus pushes expected
//               lines into a queue; a monitor pops one per drawer_start and
//               checks that coords/colour are unchanged at drawer_done. A
//               small drawer model answers each start with done 3 cycles on.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_animator;

    logic       clk         = 1'b0;
    logic       reset_n     = 1'b0;
    logic       frame_start = 1'b0;
    logic       clear_req   = 1'b0;
    logic       pause       = 1'b0;
    logic       drawer_done = 1'b0;
    logic       drawer_start;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic       pixel_color;
    logic       busy;

    typedef struct {
        logic [9:0] x0;
        logic [8:0] y0;
        logic [9:0] x1;
        logic [8:0] y1;
        logic       c;
        logic       b;
    } line_t;

    line_t exp_q[$];
    line_t cur;
    int    n_cmp      = 0;
    int    n_err      = 0;
    int    n_starts   = 0;
    int    exp_starts = 0;
    int    m_edge     = 0;
    int    m_pos      = 0;

    line_animator dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .clear_req    (clear_req),
        .pause        (pause),
        .drawer_done  (drawer_done),
        .drawer_start (drawer_start),
        .x0           (x0),
        .x1           (x1),
        .y0           (y0),
        .y1           (y1),
        .pixel_color  (pixel_color),
        .busy         (busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic push_line(input int ax, input int ay, input int bx, input int by,
                             input logic c, input logic b);
        line_t l;
        l.x0 = 10'(ax);
        l.y0 = 9'(ay);
        l.x1 = 10'(bx);
        l.y1 = 9'(by);
        l.c  = c;
        l.b  = b;
        exp_q.push_back(l);
        exp_starts++;
    endtask

    task automatic push_clear();
        for (int r = 0; r < 480; r++) push_line(0, r, 639, r, 1'b0, 1'b1);
    endtask

    task automatic push_radial(input logic c);
        int ex, ey;
        case (m_edge)
            0:       begin ex = m_pos;       ey = 0;           end
            1:       begin ex = 639;         ey = m_pos;       end
            2:       begin ex = 639 - m_pos; ey = 479;         end
            default: begin ex = 0;           ey = 479 - m_pos; end
        endcase
        push_line(320, 240, ex, ey, c, 1'b0);
    endtask

    task automatic m_adv();
        int len;
        len = (m_edge == 0 || m_edge == 2) ? 640 : 480;
        if (m_pos + 8 >= len - 1) begin
            m_edge = (m_edge + 1) % 4;
            m_pos  = 0;
        end else begin
            m_pos = m_pos + 8;
        end
    endtask

    task automatic push_step();
        push_radial(1'b0);
        m_adv();
        push_radial(1'b1);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Wait (bounded) until target starts were seen, idle for settle cycles,
    // then require the start count to be exactly target.
    task automatic wait_starts(input int target, input int settle, input string tag);
        int t;
        t = 0;
        while (n_starts < target && t < 10000) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (settle) @(posedge clk);
        #1;
        chk(tag, 32'(n_starts), 32'(target));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start"}, 32'(drawer_start), 0);
        chk({tag, "_x0"},    32'(x0), 0);
        chk({tag, "_y0"},    32'(y0), 0);
        chk({tag, "_x1"},    32'(x1), 0);
        chk({tag, "_y1"},    32'(y1), 0);
        chk({tag, "_color"}, 32'(pixel_color), 0);
        chk({tag, "_busy"},  32'(busy), 1);
    endtask

    // Drawer model: done pulse 3 cycles after start; abandoned on reset.
    initial begin : drawer_model
        bit ok;
        forever begin
            @(posedge clk); #1;
            if (reset_n && drawer_start) begin
                ok = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    if (!reset_n) ok = 1'b0;
                end
                if (ok) begin
                    drawer_done = 1'b1;
                    @(posedge clk); #1;
                    drawer_done = 1'b0;
                end
            end
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset_n && drawer_start) begin
                n_starts++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_start: got (%0d,%0d)-(%0d,%0d) c%0d, required no start",
                             x0, y0, x1, y1, pixel_color);
                end else begin
                    cur = exp_q.pop_front();
                    if (x0 !== cur.x0 || y0 !== cur.y0 || x1 !== cur.x1 || y1 !== cur.y1 ||
                        pixel_color !== cur.c || busy !== cur.b) begin
                        n_err++;
                        $display("FAIL line%0d: got (%0d,%0d)-(%0d,%0d) c%0d busy%0d, required (%0d,%0d)-(%0d,%0d) c%0d busy%0d",
                                 n_starts, x0, y0, x1, y1, pixel_color, busy,
                                 cur.x0, cur.y0, cur.x1, cur.y1, cur.c, cur.b);
                    end
                end
            end
            if (reset_n && drawer_done) begin
                n_cmp++;
                if (x0 !== cur.x0 || y0 !== cur.y0 || x1 !== cur.x1 || y1 !== cur.y1 ||
                    pixel_color !== cur.c) begin
                    n_err++;
                    $display("FAIL hold_at_done: got (%0d,%0d)-(%0d,%0d) c%0d, required (%0d,%0d)-(%0d,%0d) c%0d",
                             x0, y0, x1, y1, pixel_color, cur.x0, cur.y0, cur.x1, cur.y1, cur.c);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int tgt;

        // Reset values, then a sweep interrupted at row 100.
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        reset_n = 1'b1;
        for (int r = 0; r <= 100; r++) push_line(0, r, 639, r, 1'b0, 1'b1);
        wait_starts(exp_starts, 0, "clear_to_row100");
        #5 reset_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Full clear from row 0, then the first radial line to (0,0).
        push_clear();
        push_line(320, 240, 0, 0, 1'b1, 1'b0);
        wait_starts(exp_starts, 8, "initial_clear");
        chk("busy_idle", 32'(busy), 0);

        // One step: erase (0,0), draw (8,0); nothing after just one frame.
        push_line(320, 240, 0, 0, 1'b0, 1'b0);
        push_line(320, 240, 8, 0, 1'b1, 1'b0);
        m_pos = 8;
        pulse_frame();
        wait_starts(exp_starts - 2, 0, "one_frame_no_erase");
        pulse_frame();
        wait_starts(exp_starts, 8, "step1");

        // Pause freezes counting; two further frames needed after release.
        pause = 1'b1;
        repeat (10) pulse_frame();
        wait_starts(exp_starts, 0, "paused");
        pause = 1'b0;
        pulse_frame();
        wait_starts(exp_starts, 0, "unpause_one_frame");
        push_step();
        pulse_frame();
        wait_starts(exp_starts, 8, "unpause_two_frames");

        // Clear request during DRAW_WAIT: line completes, sweep, redraw.
        push_step();
        tgt = exp_starts;
        push_clear();
        push_radial(1'b1);
        pulse_frame();
        pulse_frame();
        wait_starts(tgt, 0, "draw_before_clear");
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_starts(exp_starts, 8, "clear_during_draw");

        // Clear request together with the expiring frame: clear wins.
        push_clear();
        push_radial(1'b1);
        pulse_frame();
        @(posedge clk); #1;
        frame_start = 1'b1;
        clear_req   = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        clear_req   = 1'b0;
        wait_starts(exp_starts, 8, "clear_wins");

        // Walk the rest of the perimeter back to TOP pos 0.
        for (int i = 0; i < 277; i++) begin
            if (m_edge == 0 && m_pos == 632) begin
                push_line(320, 240, 632, 0, 1'b0, 1'b0);
                push_line(320, 240, 639, 0, 1'b1, 1'b0);
                m_adv();
            end else if (m_edge == 3 && m_pos == 472) begin
                push_line(320, 240, 0, 7, 1'b0, 1'b0);
                push_line(320, 240, 0, 0, 1'b1, 1'b0);
                m_adv();
            end else begin
                push_step();
            end
            pulse_frame();
            pulse_frame();
            wait_starts(exp_starts, 4, "walk");
        end

        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
